// File: rtl/control_unit_fsm.sv
// Multi-cycle control unit for the MUSA core: fetches an opcode over valid/ready
// and sequences IFH->ID->EX->(MEM)->WB, with a HALT park state.
module control_unit_fsm #(
   parameter int unsigned OPCODE_W = 6,
   parameter int unsigned FUNC_W   = 6,
   parameter int unsigned BRANCH_W = 3,
   parameter int unsigned SKIP_MEM = 1,
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic                mem_ready,
   input  logic                resume,
   output logic                read_reg,
   output logic                immediat,
   output logic                control_function,
   output logic                control_alu_data,
   output logic                reg_control,
   output logic                brfl_control,
   output logic [FUNC_W-1:0]   fnction,
   output logic [BRANCH_W-1:0] branch,
   output logic                read_data,
   output logic                write_data,
   output logic                write_reg,
   output logic                push,
   output logic                pop,
   output logic                add_pc,
   output logic                write_pc,
   output logic [2:0]          state,
   output logic                halted,
   output logic                illegal_op
);

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IFH  = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   typedef struct packed {
      logic read_reg;
      logic immediat;
      logic control_function;
      logic control_alu_data;
      logic reg_control;
      logic brfl_control;
      logic read_data;
      logic write_data;
      logic write_reg;
      logic push;
      logic pop;
      logic add_pc;
   } flags_t;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(6'b000001);
   localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(6'b000010);
   localparam logic [OPCODE_W-1:0] OP_CALL  = OPCODE_W'(6'b000011);
   localparam logic [OPCODE_W-1:0] OP_RET   = OPCODE_W'(6'b000111);
   localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
   localparam logic [OPCODE_W-1:0] OP_JPC   = OPCODE_W'(6'b001001);
   localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
   localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
   localparam logic [OPCODE_W-1:0] OP_SUBI  = OPCODE_W'(6'b001110);
   localparam logic [OPCODE_W-1:0] OP_BRFL  = OPCODE_W'(6'b010001);
   localparam logic [OPCODE_W-1:0] OP_JR    = OPCODE_W'(6'b011000);
   localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
   localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

   localparam logic [FUNC_W-1:0] FN_ADD  = FUNC_W'(6'b100000);
   localparam logic [FUNC_W-1:0] FN_SUB  = FUNC_W'(6'b100010);
   localparam logic [FUNC_W-1:0] FN_AND  = FUNC_W'(6'b100100);
   localparam logic [FUNC_W-1:0] FN_OR   = FUNC_W'(6'b100101);
   localparam logic [FUNC_W-1:0] FN_BRFL = FUNC_W'(6'b111111);

   localparam logic [BRANCH_W-1:0] BR_JR   = BRANCH_W'(3'b001);
   localparam logic [BRANCH_W-1:0] BR_CALL = BRANCH_W'(3'b010);
   localparam logic [BRANCH_W-1:0] BR_JPC  = BRANCH_W'(3'b100);

   state_t              state_q, state_d;
   logic [OPCODE_W-1:0] opcode_q, opcode_d;
   flags_t              cw_q, cw_d;
   logic [FUNC_W-1:0]   fn_q, fn_d;
   logic [BRANCH_W-1:0] br_q, br_d;

   flags_t              out_q, out_d;
   logic [FUNC_W-1:0]   fn_out_q, fn_out_d;
   logic [BRANCH_W-1:0] br_out_q, br_out_d;
   logic                write_pc_q, write_pc_d;
   logic                instr_ready_q, instr_ready_d;
   logic                halted_q, halted_d;
   logic                illegal_op_q, illegal_op_d;

   flags_t              dec_flags;
   logic [FUNC_W-1:0]   dec_fn;
   logic [BRANCH_W-1:0] dec_br;
   logic                dec_legal;
   logic                dec_halt;
   logic                is_mem;
   logic                level_on;

   // Opcode capture: only an accepted IFH handshake may change the held opcode
   always_comb begin
      opcode_d = opcode_q;
      if ((state_q == S_IFH) && instr_valid) begin
         opcode_d = opcode;
      end
   end

   // Decoder works on the opcode that will be held next cycle
   always_comb begin
      dec_flags = '0;
      dec_fn    = '0;
      dec_br    = '0;
      dec_legal = 1'b1;
      dec_halt  = 1'b0;
      case (opcode_d)
         OP_RTYPE: begin
            dec_flags.read_reg  = 1'b1;
            dec_flags.write_reg = 1'b1;
         end
         OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_LW: begin
            dec_flags.read_reg         = 1'b1;
            dec_flags.write_reg        = 1'b1;
            dec_flags.immediat         = 1'b1;
            dec_flags.control_function = 1'b1;
            dec_flags.reg_control      = 1'b1;
            case (opcode_d)
               OP_SUBI: dec_fn = FN_SUB;
               OP_ANDI: dec_fn = FN_AND;
               OP_ORI:  dec_fn = FN_OR;
               default: dec_fn = FN_ADD;
            endcase
            if (opcode_d == OP_LW) begin
               dec_flags.control_alu_data = 1'b1;
               dec_flags.read_data        = 1'b1;
            end
         end
         OP_SW: begin
            dec_flags.read_reg         = 1'b1;
            dec_flags.immediat         = 1'b1;
            dec_flags.control_function = 1'b1;
            dec_flags.control_alu_data = 1'b1;
            dec_flags.write_data       = 1'b1;
            dec_fn                     = FN_ADD;
         end
         OP_CALL: begin
            dec_br         = BR_CALL;
            dec_flags.push = 1'b1;
         end
         OP_RET: begin
            dec_flags.pop    = 1'b1;
            dec_flags.add_pc = 1'b1;
         end
         OP_JR: begin
            dec_flags.read_reg = 1'b1;
            dec_br             = BR_JR;
         end
         OP_JPC: dec_br = BR_JPC;
         OP_BRFL: begin
            dec_flags.read_reg         = 1'b1;
            dec_flags.control_function = 1'b1;
            dec_flags.brfl_control     = 1'b1;
            dec_fn                     = FN_BRFL;
         end
         OP_NOP:  dec_legal = 1'b1;
         OP_HALT: dec_halt  = 1'b1;
         default: dec_legal = 1'b0;
      endcase
   end

   assign is_mem = cw_q.read_data | cw_q.write_data;

   // Next state and control-word load
   always_comb begin
      state_d = state_q;
      cw_d    = cw_q;
      fn_d    = fn_q;
      br_d    = br_q;
      case (state_q)
         S_IFH: begin
            if (instr_valid) begin
               state_d = S_ID;
            end
         end
         S_ID: begin
            if (dec_halt) begin
               state_d = S_HALT;
            end else begin
               state_d = S_EX;
               cw_d    = dec_flags;
               fn_d    = dec_fn;
               br_d    = dec_br;
            end
         end
         S_EX: begin
            if (is_mem || (SKIP_MEM == 0)) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (!(is_mem && (MEM_WAIT != 0) && !mem_ready)) begin
               state_d = S_WB;
            end
         end
         S_WB: state_d = S_IFH;
         S_HALT: begin
            if (resume) begin
               state_d = S_IFH;
            end
         end
         default: state_d = S_IFH;
      endcase
   end

   assign level_on = (state_d == S_EX) || (state_d == S_MEM) || (state_d == S_WB);

   // Outputs are registered from the next state so they line up with the state they describe
   always_comb begin
      out_d    = '0;
      fn_out_d = '0;
      br_out_d = '0;
      if (level_on) begin
         out_d.read_reg         = cw_d.read_reg;
         out_d.immediat         = cw_d.immediat;
         out_d.control_function = cw_d.control_function;
         out_d.control_alu_data = cw_d.control_alu_data;
         out_d.reg_control      = cw_d.reg_control;
         out_d.brfl_control     = cw_d.brfl_control;
         fn_out_d               = fn_d;
         br_out_d               = br_d;
      end
      if (state_d == S_MEM) begin
         out_d.read_data  = cw_d.read_data;
         out_d.write_data = cw_d.write_data;
      end
      if (state_d == S_WB) begin
         out_d.write_reg = cw_d.write_reg;
         out_d.push      = cw_d.push;
         out_d.pop       = cw_d.pop;
         out_d.add_pc    = cw_d.add_pc;
      end
      write_pc_d    = (state_d == S_WB);
      instr_ready_d = (state_d == S_IFH);
      halted_d      = (state_d == S_HALT);
      illegal_op_d  = (state_q == S_IFH) && (state_d == S_ID) && !dec_legal;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IFH;
         opcode_q      <= '0;
         cw_q          <= '0;
         fn_q          <= '0;
         br_q          <= '0;
         out_q         <= '0;
         fn_out_q      <= '0;
         br_out_q      <= '0;
         write_pc_q    <= 1'b0;
         instr_ready_q <= 1'b1;
         halted_q      <= 1'b0;
         illegal_op_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         opcode_q      <= opcode_d;
         cw_q          <= cw_d;
         fn_q          <= fn_d;
         br_q          <= br_d;
         out_q         <= out_d;
         fn_out_q      <= fn_out_d;
         br_out_q      <= br_out_d;
         write_pc_q    <= write_pc_d;
         instr_ready_q <= instr_ready_d;
         halted_q      <= halted_d;
         illegal_op_q  <= illegal_op_d;
      end
   end

   assign instr_ready      = instr_ready_q;
   assign read_reg         = out_q.read_reg;
   assign immediat         = out_q.immediat;
   assign control_function = out_q.control_function;
   assign control_alu_data = out_q.control_alu_data;
   assign reg_control      = out_q.reg_control;
   assign brfl_control     = out_q.brfl_control;
   assign fnction          = fn_out_q;
   assign branch           = br_out_q;
   assign read_data        = out_q.read_data;
   assign write_data       = out_q.write_data;
   assign write_reg        = out_q.write_reg;
   assign push             = out_q.push;
   assign pop              = out_q.pop;
   assign add_pc           = out_q.add_pc;
   assign write_pc         = write_pc_q;
   assign state            = state_q;
   assign halted           = halted_q;
   assign illegal_op       = illegal_op_q;

endmodule
